out_display_driver: RTL and testbench



---
 rtl/out_display_pkg.sv | 43 ++++
 rtl/out_display_driver_bin2bcd_seq.sv | 68 ++++++
 rtl/out_display_driver.sv | 167 ++++++++++++++++
 tb/tb_out_display_driver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_display_pkg.sv
// Shared types and 7-segment encodings for the output-register display driver.
// Segment bit order is bit0=a through bit6=g, active-high.
package out_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal nibbles cannot come out of the converter; blank them anyway.
  function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
    logic [6:0] w_seg;
    case (i_digit)
      4'd0:    w_seg = SEG_0;
      4'd1:    w_seg = SEG_1;
      4'd2:    w_seg = SEG_2;
      4'd3:    w_seg = SEG_3;
      4'd4:    w_seg = SEG_4;
      4'd5:    w_seg = SEG_5;
      4'd6:    w_seg = SEG_6;
      4'd7:    w_seg = SEG_7;
      4'd8:    w_seg = SEG_8;
      4'd9:    w_seg = SEG_9;
      default: w_seg = SEG_BLANK;
    endcase
    return w_seg;
  endfunction

endpackage

// File: rtl/out_display_driver_bin2bcd_seq.sv
// Sequential double-dabble engine: one add-3/shift iteration per cycle.
// o_done is high during the final iteration; o_bcd holds the result from the next cycle.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);
  import out_display_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_active;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_bcd_nxt;
  logic [WIDTH-1:0]    w_bin_nxt;
  logic                w_last;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    // {bcd, bin} shifted left by one as a single long register
    w_bcd_nxt = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
    w_bin_nxt = {r_bin[WIDTH-2:0], 1'b0};
  end

  assign w_last = r_active && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_bin    <= i_bin;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bin <= w_bin_nxt;
      r_bcd <= w_bcd_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_busy = r_active;
  assign o_done = w_last;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/out_display_driver.sv
// Multiplexed 7-segment driver for the CPU output register: binary->BCD, commit, blanking, scan.
// Define OUT_DISPLAY_SIGNED_EN to treat i_load_data as two's complement with a minus digit.
module out_display_driver #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_enable,
  input  logic [WIDTH-1:0]  i_load_data,
  output logic [6:0]        o_seg,
  output logic [DIGITS-1:0] o_dig,
  output logic              o_busy
);
  import out_display_pkg::*;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_commit;

  logic [WIDTH-1:0]    w_mag;
  logic                w_eng_busy;
  logic                w_eng_done;
  logic [4*DIGITS-1:0] w_bcd;

  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] w_disp_nxt;
  logic [PW-1:0]       r_pre;
  logic [PW-1:0]       w_pre_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic                w_pre_wrap;
  logic [IW-1:0]       w_msd;
  logic [3:0]          w_dig_val;
  logic [6:0]          w_seg_nxt;
  logic [DIGITS-1:0]   w_dig_nxt;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dig;

`ifdef OUT_DISPLAY_SIGNED_EN
  logic r_neg_pend;
  logic r_disp_neg;
  logic w_disp_neg_nxt;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  assign w_mag = i_load_data[WIDTH-1] ? (~i_load_data + WIDTH'(1)) : i_load_data;
  assign w_disp_neg_nxt = w_commit ? r_neg_pend : r_disp_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_pend <= 1'b0;
      r_disp_neg <= 1'b0;
    end else begin
      if (i_load_enable) begin
        r_neg_pend <= i_load_data[WIDTH-1];
      end
      r_disp_neg <= w_disp_neg_nxt;
    end
  end
`else
  assign w_mag = i_load_data;
`endif

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_load_enable),
    .i_bin   (w_mag),
    .o_busy  (w_eng_busy),
    .o_done  (w_eng_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A load in any state restarts the engine; only an uninterrupted COMMIT updates the display.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load_enable) w_state_nxt = CONVERT;
      end
      CONVERT: begin
        if (i_load_enable)    w_state_nxt = CONVERT;
        else if (w_eng_done)  w_state_nxt = COMMIT;
        else if (!w_eng_busy) w_state_nxt = IDLE;
      end
      COMMIT: begin
        if (i_load_enable) begin
          w_state_nxt = CONVERT;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy = (r_state != IDLE);

  assign w_pre_wrap = (r_pre == PW'(SCAN_DIV - 1));
  assign w_pre_nxt  = w_pre_wrap ? '0 : r_pre + PW'(1);
  assign w_disp_nxt = w_commit ? w_bcd : r_disp;

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_pre_wrap) begin
      w_idx_nxt = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  // Output registers look at next-cycle index and digits so a commit and a
  // scan advance landing on the same edge are shown together.
  always_comb begin
    w_msd     = '0;
    w_dig_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_disp_nxt[4*i +: 4] != 4'd0) w_msd = IW'(i);
      if (w_idx_nxt == IW'(i))          w_dig_val = w_disp_nxt[4*i +: 4];
    end
    w_seg_nxt = SEG_BLANK;
    if (w_idx_nxt <= w_msd) begin
      w_seg_nxt = seg_decode(w_dig_val);
`ifdef OUT_DISPLAY_SIGNED_EN
    end else if (w_disp_neg_nxt &&
                 ({1'b0, w_idx_nxt} == ({1'b0, w_msd} + (IW+1)'(1)))) begin
      w_seg_nxt = SEG_MINUS;
`endif
    end
    w_dig_nxt = DIGITS'(1) << w_idx_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
      r_pre  <= '0;
      r_idx  <= '0;
      r_seg  <= SEG_BLANK;
      r_dig  <= '0;
    end else begin
      r_disp <= w_disp_nxt;
      r_pre  <= w_pre_nxt;
      r_idx  <= w_idx_nxt;
      r_seg  <= w_seg_nxt;
      r_dig  <= w_dig_nxt;
    end
  end

  assign o_seg = r_seg;
  assign o_dig = r_dig;

endmodule

// File: tb/tb_out_display_driver.sv
// Bench for out_display_driver with a short scan period; vector table plus hand-written
// sequences for restart, reset mid-conversion and scan timing.
module tb_out_display_driver;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int NVEC     = 6;

  logic              clk;
  logic              rst_n;
  logic              i_load_enable;
  logic [WIDTH-1:0]  i_load_data;
  logic [6:0]        o_seg;
  logic [DIGITS-1:0] o_dig;
  logic              o_busy;

  out_display_driver #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load_enable (i_load_enable),
    .i_load_data   (i_load_data),
    .o_seg         (o_seg),
    .o_dig         (o_dig),
    .o_busy        (o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [WIDTH-1:0]   value;
    logic [3:0][6:0]    segs;   // segs[0] = least significant digit
  } vec_t;

  vec_t       tbl [NVEC];
  logic [6:0] exp_q [$];
  int         n_checks;
  int         n_fail;
  bit         mon_en;
  int         bad_45;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [WIDTH-1:0] v, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    vec_t r;
    r.value = v;
    r.segs  = {s3, s2, s1, s0};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic load(input logic [WIDTH-1:0] v);
    i_load_enable = 1'b1;
    i_load_data   = v;
    tick();
    i_load_enable = 1'b0;
    i_load_data   = $urandom_range(0, 255);
  endtask

  task automatic push_exp(input logic [3:0][6:0] s);
    for (int i = 0; i < DIGITS; i++) exp_q.push_back(s[i]);
  endtask

  // counts cycles with o_busy high starting from the current sample
  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (o_busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  // scoreboard: observe one full scan, pop expected codes per digit
  task automatic collect(input string name);
    logic [6:0] seen [DIGITS];
    logic [6:0] e;
    int bad;
    bad = 0;
    for (int i = 0; i < DIGITS; i++) seen[i] = 'x;
    for (int c = 0; c < 2 * DIGITS * SCAN_DIV; c++) begin
      if ($onehot(o_dig)) begin
        for (int i = 0; i < DIGITS; i++) if (o_dig[i]) seen[i] = o_seg;
      end else begin
        bad++;
      end
      tick();
    end
    check({name, "_onehot"}, bad, 0);
    for (int i = 0; i < DIGITS; i++) begin
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_dig%0d", name, i), seen[i], e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (o_seg == 7'h66 || o_seg == 7'h6D)) bad_45++;
  end

  initial begin
    int cyc;
    int idx;
    int hold;
    logic [DIGITS-1:0] prev;

    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    bad_45   = 0;
    rst_n         = 1'b0;
    i_load_enable = 1'b0;
    i_load_data   = '0;

`ifdef OUT_DISPLAY_SIGNED_EN
    tbl[0] = mk(8'd123, 7'h4F, 7'h5B, 7'h06, 7'h00);
    tbl[1] = mk(8'h80,  7'h7F, 7'h5B, 7'h06, 7'h40);
    tbl[2] = mk(8'hFF,  7'h06, 7'h40, 7'h00, 7'h00);
    tbl[3] = mk(8'h64,  7'h3F, 7'h3F, 7'h06, 7'h00);
    tbl[4] = mk(8'hF6,  7'h3F, 7'h06, 7'h40, 7'h00);
    tbl[5] = mk(8'd0,   7'h3F, 7'h00, 7'h00, 7'h00);
`else
    tbl[0] = mk(8'd123, 7'h4F, 7'h5B, 7'h06, 7'h00);
    tbl[1] = mk(8'd255, 7'h6D, 7'h6D, 7'h5B, 7'h00);
    tbl[2] = mk(8'd9,   7'h6F, 7'h00, 7'h00, 7'h00);
    tbl[3] = mk(8'd10,  7'h3F, 7'h06, 7'h00, 7'h00);
    tbl[4] = mk(8'd200, 7'h3F, 7'h3F, 7'h5B, 7'h00);
    tbl[5] = mk(8'd0,   7'h3F, 7'h00, 7'h00, 7'h00);
`endif

    // reset state
    #12;
    check("reset_seg", o_seg, 7'h00);
    check("reset_dig", o_dig, 4'b0000);
    check("reset_busy", o_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("first_dig", o_dig, 4'b0001);
    check("first_seg", o_seg, 7'h3F);
    push_exp({7'h00, 7'h00, 7'h00, 7'h3F});
    collect("reset_scan");

    // vector table
    for (int v = 0; v < NVEC; v++) begin
      push_exp(tbl[v].segs);
      load(tbl[v].value);
      wait_busy(cyc);
      check($sformatf("vec%0d_busy_cycles", v), cyc, 9);
      idx = -1;
      for (int i = 0; i < DIGITS; i++) if (o_dig[i]) idx = i;
      if (idx >= 0) check($sformatf("vec%0d_commit_seg", v), o_seg, tbl[v].segs[idx]);
      else          check($sformatf("vec%0d_commit_dig", v), o_dig, 4'b0001);
      collect($sformatf("vec%0d", v));
    end

    // restart: 45 aborted mid-conversion by 7
    mon_en = 1'b1;
    push_exp({7'h00, 7'h00, 7'h00, 7'h07});
    load(8'd45);
    tick();
    tick();
    load(8'd7);
    wait_busy(cyc);
    check("restart_busy_cycles", cyc, 9);
    collect("restart");
    mon_en = 1'b0;
    check("restart_no_partial", bad_45, 0);

    // scan timing: each digit held SCAN_DIV cycles, one-hot rotation
    prev = o_dig;
    cyc  = 0;
    while (o_dig == prev && cyc < 20) begin
      cyc++;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      prev = o_dig;
      hold = 0;
      while (o_dig == prev && hold < 20) begin
        hold++;
        tick();
      end
      check($sformatf("scan_hold%0d", k), hold, SCAN_DIV);
      check($sformatf("scan_next%0d", k), o_dig, {prev[DIGITS-2:0], prev[DIGITS-1]});
    end

    // reset mid-conversion
    load(8'd200);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("midreset_busy", o_busy, 1'b0);
    check("midreset_dig", o_dig, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("midreset_first_dig", o_dig, 4'b0001);
    check("midreset_first_seg", o_seg, 7'h3F);
    push_exp({7'h00, 7'h00, 7'h00, 7'h3F});
    collect("midreset_scan");

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
